ad_wave_capture: RTL

Receive-side counterpart of the DAC waveform path: drives the ADC sample clock, registers the ADC output bus, waits for a programmable rising-edge level trigger, then writes a fixed-length, optionally decimated record of samples into an external single-port capture RAM. The block sits between the ADC pins and the capture RAM. A host-side reader drains the RAM after `done`.

---
 rtl/ad_pkg.sv | 15 +
 rtl/ad_trig_detect.sv | 20 ++
 rtl/ad_wave_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// Shared types and default widths for the ADC waveform capture path.
package ad_pkg;

    localparam int unsigned DEF_DATA_W = 10;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DEC_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWaitTrig,
        StCapture,
        StDone
    } ad_state_e;

endpackage

// File: rtl/ad_trig_detect.sv
// Rising-edge level trigger: fires when the sample stream crosses the threshold upward.
module ad_trig_detect #(
    parameter int unsigned DATA_W = 10
) (
    input  logic [DATA_W-1:0] smp,
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] level,
    input  logic              arm_q,
    input  logic              trig_en,
    output logic              trig
);

    logic crossing;

    assign crossing = (prev < level) && (smp >= level);

    // With the trigger disabled the caller fires on its first waiting cycle.
    assign trig = trig_en ? (arm_q && crossing) : 1'b1;

endmodule

// File: rtl/ad_wave_capture.sv
// ADC capture front end: samples the ADC bus, waits for a level trigger and
// writes a fixed-length, optionally decimated record into the capture RAM.
module ad_wave_capture
    import ad_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEC_W  = DEF_DEC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ad_clk,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              start,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DEC_W-1:0]  decim,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    ad_state_e state_q, state_d;

    logic [DATA_W-1:0] smp_q, prev_q;
    logic              trig_en_q, trig_en_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [DEC_W-1:0]  decim_q, decim_d;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic              arm_q, arm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trig;
    logic              last_written;

    assign ad_clk = ~clk;

    ad_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .smp     (smp_q),
        .prev    (prev_q),
        .level   (level_q),
        .arm_q   (arm_q),
        .trig_en (trig_en_q),
        .trig    (trig)
    );

    // The final address was strobed on the previous edge; no further writes.
    assign last_written = wr_en_q && (&wr_addr_q);

    always_comb begin
        state_d   = state_q;
        trig_en_d = trig_en_q;
        level_d   = level_q;
        decim_d   = decim_q;
        dec_cnt_d = dec_cnt_q;
        arm_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    trig_en_d = trig_en;
                    level_d   = trig_level;
                    decim_d   = decim;
                    state_d   = StWaitTrig;
                end
            end
            StWaitTrig: begin
                arm_d = 1'b1;
                if (trig) begin
                    state_d   = StCapture;
                    arm_d     = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = smp_q;
                    dec_cnt_d = '0;
                end
            end
            StCapture: begin
                if (last_written) begin
                    state_d = StDone;
                end else if (dec_cnt_q == decim_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = smp_q;
                    dec_cnt_d = '0;
                end else begin
                    dec_cnt_d = dec_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StWaitTrig) || (state_d == StCapture);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            smp_q     <= '0;
            prev_q    <= '0;
            trig_en_q <= 1'b0;
            level_q   <= '0;
            decim_q   <= '0;
            dec_cnt_q <= '0;
            arm_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= ad_data;
            prev_q    <= smp_q;
            trig_en_q <= trig_en_d;
            level_q   <= level_d;
            decim_q   <= decim_d;
            dec_cnt_q <= dec_cnt_d;
            arm_q     <= arm_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
